// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSetup   = 2'd1,
        StStrobe  = 2'd2,
        StRecover = 2'd3
    } state_e;

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } port_e;

    localparam int unsigned DefAddrW = 18;
    localparam int unsigned DefDataW = 16;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// CPU-side request/acknowledge bundle: port A (fetch, read-only) and port B (data, read/write).
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) ();

    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata
    );

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata
    );

endinterface

// File: rtl/sram_port_arbiter_bus_driver.sv
// Registered SRAM address/strobe outputs and the tristate data buffer.
module sram_port_arbiter_bus_driver #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ce_n_d_i,
    input  logic              oe_n_d_i,
    input  logic              we_n_d_i,
    input  logic              drive_en_d_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_ce_n_o,
    output logic              mem_oe_n_o,
    output logic              mem_we_n_o,
    output logic [DATA_W-1:0] rd_data_o,
    inout  wire  [DATA_W-1:0] mem_data_io
);

    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              ce_n_q, oe_n_q, we_n_q, drive_en_q;

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load_i) begin
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            drive_en_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ce_n_q     <= ce_n_d_i;
            oe_n_q     <= oe_n_d_i;
            we_n_q     <= we_n_d_i;
            drive_en_q <= drive_en_d_i;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_ce_n_o  = ce_n_q;
    assign mem_oe_n_o  = oe_n_q;
    assign mem_we_n_o  = we_n_q;
    assign mem_data_io = drive_en_q ? wdata_q : {DATA_W{1'bz}};
    assign rd_data_o   = mem_data_io;

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one asynchronous SRAM and sequences each access.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = DefAddrW,
    parameter int unsigned DATA_W        = DefDataW,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_port_arbiter_if.slave  cpu,
    inout  wire  [DATA_W-1:0]   mem_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_oe_n,
    output logic                mem_we_n,
    output logic                mem_ce_n,
    output logic                busy
);

    state_e            state_d, state_q;
    logic [3:0]        cnt_d, cnt_q;
    port_e             grant_d, grant_q;
    port_e             last_grant_d, last_grant_q;
    port_e             pick;
    logic              we_d, we_q;
    logic              a_ack_d, a_ack_q;
    logic              b_ack_d, b_ack_q;
    logic [DATA_W-1:0] a_rdata_d, a_rdata_q;
    logic [DATA_W-1:0] b_rdata_d, b_rdata_q;

    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic              ce_n_d, oe_n_d, we_n_d, drive_en_d;
    logic [DATA_W-1:0] rd_data;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        if (cpu.a_req && cpu.b_req) begin
            pick = (last_grant_q == PortA) ? PortB : PortA;
        end else if (cpu.a_req) begin
            pick = PortA;
        end else begin
            pick = PortB;
        end
    end

    assign load_addr = (pick == PortA) ? cpu.a_addr : cpu.b_addr;

    // Strobe/enable values are the next cycle's bus state; the driver registers them.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        load         = 1'b0;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        drive_en_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu.a_req || cpu.b_req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    we_d         = (pick == PortB) && cpu.b_we;
                    load         = 1'b1;
                    ce_n_d       = 1'b0;
                    drive_en_d   = we_d;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                cnt_d      = 4'(ACCESS_CYCLES - 1);
                ce_n_d     = 1'b0;
                oe_n_d     = we_q;
                we_n_d     = !we_q;
                drive_en_d = we_q;
                state_d    = StStrobe;
            end
            StStrobe: begin
                drive_en_d = we_q;
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (grant_q == PortA) a_rdata_d = rd_data;
                        else                  b_rdata_d = rd_data;
                    end
                    a_ack_d = (grant_q == PortA);
                    b_ack_d = (grant_q == PortB);
                    state_d = StRecover;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    ce_n_d = 1'b0;
                    oe_n_d = we_q;
                    we_n_d = !we_q;
                end
            end
            StRecover: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            grant_q      <= PortA;
            last_grant_q <= PortA;
            we_q         <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    sram_port_arbiter_bus_driver #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_drv (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .addr_i       (load_addr),
        .wdata_i      (cpu.b_wdata),
        .ce_n_d_i     (ce_n_d),
        .oe_n_d_i     (oe_n_d),
        .we_n_d_i     (we_n_d),
        .drive_en_d_i (drive_en_d),
        .mem_addr_o   (mem_addr),
        .mem_ce_n_o   (mem_ce_n),
        .mem_oe_n_o   (mem_oe_n),
        .mem_we_n_o   (mem_we_n),
        .rd_data_o    (rd_data),
        .mem_data_io  (mem_data)
    );

    assign cpu.a_ack   = a_ack_q;
    assign cpu.b_ack   = b_ack_q;
    assign cpu.a_rdata = a_rdata_q;
    assign cpu.b_rdata = b_rdata_q;
    assign busy        = (state_q != StIdle);

endmodule
